// File: rtl/mem_fill_writer.sv
// mem_fill_writer: fills a 2^ADDR_WIDTH-deep memory from a valid/ready byte stream, one pass per start.
// Optional running checksum output CSUM when MEM_FILL_CHECKSUM_EN is defined.
`default_nettype none

module mem_fill_writer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic [DATA_WIDTH-1:0] DATA,
    output logic                  WE,
    output logic                  busy,
`ifdef MEM_FILL_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] CSUM,
`endif
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_LAST = '1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_we;
    logic                  w_xfer;
`ifdef MEM_FILL_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;
`endif

    // Handshake status is a pure decode of the state register.
    assign in_ready = (r_state == S_WRITE);
    assign busy     = (r_state == S_WRITE);
    assign done     = (r_state == S_DONE);
    assign w_xfer   = in_valid & in_ready;

    assign ADDR = r_addr;
    assign DATA = r_data;
    assign WE   = r_we;
`ifdef MEM_FILL_CHECKSUM_EN
    assign CSUM = r_csum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_we     <= 1'b0;
`ifdef MEM_FILL_CHECKSUM_EN
            r_csum   <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state  <= S_WRITE;
                        r_wr_ptr <= '0;
`ifdef MEM_FILL_CHECKSUM_EN
                        r_csum   <= '0;
`endif
                    end
                end
                S_WRITE: begin
                    if (w_xfer) begin
                        r_addr   <= r_wr_ptr;
                        r_data   <= in_data;
                        r_we     <= 1'b1;
                        r_wr_ptr <= r_wr_ptr + 1'b1;
`ifdef MEM_FILL_CHECKSUM_EN
                        r_csum   <= r_csum + in_data;
`endif
                        // Leaving on the last address keeps the wrapped pointer from writing again.
                        if (r_wr_ptr == c_LAST) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_fill_writer.sv
// tb_mem_fill_writer: directed vector table plus randomized full passes checked against a behavioural model.
// Checksum comparisons are included when MEM_FILL_CHECKSUM_EN is defined.
`default_nettype none

module tb_mem_fill_writer;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] DATA;
    logic          WE;
    logic          busy;
    logic          done;
`ifdef MEM_FILL_CHECKSUM_EN
    logic [DW-1:0] CSUM;
`endif

    mem_fill_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ADDR     (ADDR),
        .DATA     (DATA),
        .WE       (WE),
        .busy     (busy),
`ifdef MEM_FILL_CHECKSUM_EN
        .CSUM     (CSUM),
`endif
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pass phase, number of bytes accepted so far, last write seen by memory.
    int            m_phase;   // 0 waiting for start, 1 filling, 2 filled
    int            m_cnt;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_csum;

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_we = 0; m_addr = '0; m_data = '0; m_csum = '0;
    endtask

    task automatic check(input string tag);
        bit bad;
        bad = (WE !== m_we) || (ADDR !== m_addr) || (DATA !== m_data) ||
              (in_ready !== (m_phase == 1)) || (busy !== (m_phase == 1)) || (done !== (m_phase == 2));
`ifdef MEM_FILL_CHECKSUM_EN
        bad = bad || (CSUM !== m_csum);
`endif
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL %s t=%0t got we=%b addr=%0d data=%h rdy=%b busy=%b done=%b want we=%b addr=%0d data=%h rdy=%b busy=%b done=%b",
                     tag, $time, WE, ADDR, DATA, in_ready, busy, done,
                     m_we, m_addr, m_data, m_phase == 1, m_phase == 1, m_phase == 2);
        end
    endtask

    task automatic expect_int(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare on the falling edge.
    task automatic cyc(input logic s, input logic v, input logic [DW-1:0] d);
        start = s; in_valid = v; in_data = d;
        @(posedge clk);
        m_we = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (m_phase == 1) begin
            if (v) begin
                m_we   = 1'b1;
                m_addr = AW'(m_cnt);
                m_data = d;
                m_csum = m_csum + d;
                m_cnt++;
                if (m_cnt == DEPTH) m_phase = 2;
            end
        end else if (s) begin
            m_phase = 1; m_cnt = 0; m_csum = '0;
        end
        @(negedge clk);
        check("cycle");
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("reset-immediate");
        @(posedge clk);
        @(negedge clk);
        check("reset-held");
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 8'h5A);
        cyc(1'b0, 1'b1, 8'hA5);
    endtask

    // vmode: 0 always valid, 1 valid pattern 1,0,0,1, 2 random gaps.
    // dmode: 0 addr low byte, 1 random, 2 0xFF, 3 0x01, 4 0x03 at address 0 only.
    task automatic run_pass(input int vmode, input int dmode, input int start_at, input int rst_at);
        int k = 0;
        int we_n = 0;
        logic v, s;
        logic [DW-1:0] d;
        cyc(1'b1, 1'b0, 8'h00);
        while (m_phase == 1 && k < 5000) begin
            if (rst_at >= 0 && m_cnt == rst_at) begin
                do_reset();
                return;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (k % 4 == 0) || (k % 4 == 3);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            case (dmode)
                0:       d = DW'(m_cnt);
                1:       d = DW'($urandom);
                2:       d = 8'hFF;
                3:       d = 8'h01;
                default: d = (m_cnt == 0) ? 8'h03 : 8'h00;
            endcase
            s = (start_at >= 0 && m_cnt == start_at) || (vmode == 2 && $urandom_range(0, 15) == 0);
            cyc(s, v, d);
            if (WE === 1'b1) we_n++;
            k++;
        end
        expect_int("pass-timeout", (k < 5000) ? 1 : 0, 1);
        expect_int("pass-write-count", we_n, DEPTH);
        expect_int("pass-last-addr", int'(ADDR), DEPTH - 1);
    endtask

    typedef struct {
        logic          s, v;
        logic [DW-1:0] d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          rdy, bsy, dn;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #400_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 1'b1, 8'h55, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'hAA, 1'b0, 10'd0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h11, 1'b1, 10'd0, 8'h11, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 8'h22, 1'b0, 10'd0, 8'h11, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'h33, 1'b1, 10'd1, 8'h33, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'h44, 1'b1, 10'd2, 8'h44, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 10'd2, 8'h44, 1'b1, 1'b1, 1'b0};

        model_reset();
        #2 rst_n = 1'b0;
        #1 check("power-on-reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].s, tbl[i].v, tbl[i].d);
            n_vec++;
            if (WE !== tbl[i].we || ADDR !== tbl[i].addr || DATA !== tbl[i].data ||
                in_ready !== tbl[i].rdy || busy !== tbl[i].bsy || done !== tbl[i].dn) begin
                n_err++;
                $display("FAIL table[%0d] got we=%b addr=%0d data=%h rdy=%b busy=%b done=%b want we=%b addr=%0d data=%h rdy=%b busy=%b done=%b",
                         i, WE, ADDR, DATA, in_ready, busy, done, tbl[i].we, tbl[i].addr, tbl[i].data,
                         tbl[i].rdy, tbl[i].bsy, tbl[i].dn);
            end
        end

        do_reset();
        run_pass(0, 0, -1, -1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'hC3);
        run_pass(1, 1, -1, -1);
        run_pass(0, 1, 500, -1);
        cyc(1'b0, 1'b1, 8'h77);
        cyc(1'b1, 1'b1, 8'h77);
        expect_int("restart-done-low", int'(done), 0);
        cyc(1'b0, 1'b1, 8'h9C);
        expect_int("restart-addr0", int'(ADDR), 0);
        run_pass(0, 1, -1, 300);
        run_pass(0, 0, -1, -1);
        run_pass(2, 1, -1, -1);

        run_pass(2, 2, -1, -1);
`ifdef MEM_FILL_CHECKSUM_EN
        expect_int("csum-ff", int'(CSUM), 8'h00);
`endif
        run_pass(0, 3, -1, -1);
`ifdef MEM_FILL_CHECKSUM_EN
        expect_int("csum-01", int'(CSUM), 8'h00);
`endif
        run_pass(1, 4, -1, -1);
`ifdef MEM_FILL_CHECKSUM_EN
        expect_int("csum-03", int'(CSUM), 8'h03);
        cyc(1'b0, 1'b1, 8'hEE);
        expect_int("csum-stable-done", int'(CSUM), 8'h03);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_fill_writer.md
MEM_FILL_WRITER -- requirements
Module: mem_fill_writer

Interface
REQ-001: Parameter ADDR_WIDTH, default 10, memory address width; depth is 2^ADDR_WIDTH (1024 bytes).
REQ-002: Parameter DATA_WIDTH, default 8, memory word width.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: start  input  1  level-sampled request to begin a fill pass.
REQ-006: in_valid  input  1  source has a byte on in_data.
REQ-007: in_data  input  DATA_WIDTH  byte to be written.
REQ-008: in_ready  output  1  block accepts in_data this cycle.
REQ-009: ADDR  output  ADDR_WIDTH  memory write address, registered.
REQ-010: DATA  output  DATA_WIDTH  memory write data, registered.
REQ-011: WE  output  1  memory write strobe, one cycle per write, registered.
REQ-012: busy  output  1  high in state WRITE.
REQ-013: done  output  1  high in state DONE.

Function
REQ-014: The FSM SHALL have exactly three states: IDLE, WRITE and DONE.
REQ-015: IDLE -> WRITE when start=1; on that edge wr_ptr SHALL clear to 0.
REQ-016: in_ready SHALL equal 1 in WRITE and 0 in all other states, decoded combinationally from state only.
REQ-017: A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_valid without in_ready SHALL have no effect.
REQ-018: On a transfer: DATA<=in_data, ADDR<=wr_ptr, WE<=1, wr_ptr<=wr_ptr+1 (modulo 2^ADDR_WIDTH); write latency is one cycle.
REQ-019: On any edge without a transfer, WE SHALL be 0 for the following cycle; ADDR and DATA SHALL hold their last values.
REQ-020: A transfer with wr_ptr=2^ADDR_WIDTH-1 SHALL move WRITE -> DONE; the last WE pulse and the rise of done SHALL coincide in the same cycle.
REQ-021: Exactly 2^ADDR_WIDTH transfers SHALL occur per pass, to addresses 0..2^ADDR_WIDTH-1 in ascending order, with no skipped or repeated address.
REQ-022: start SHALL be ignored in WRITE; gaps in in_valid SHALL stall the pass without data loss.
REQ-023: DONE SHALL hold done=1 until start=1, then go to WRITE with wr_ptr=0 and done=0 on the next cycle.
REQ-024: Wrap of wr_ptr from 1023 to 0 SHALL never produce a 1025th write.

Reset
REQ-025: rst_n=0 SHALL immediately force: state=IDLE, wr_ptr=0, ADDR=0, DATA=0, WE=0, busy=0, done=0, in_ready=0.
REQ-026: Reset asserted mid-pass SHALL abandon the pass; no WE pulse SHALL occur until a new start after reset release.
REQ-027: After reset release the block SHALL remain in IDLE until start=1 is sampled.

Configuration
REQ-028: Macro MEM_FILL_CHECKSUM_EN defined: an output CSUM [DATA_WIDTH-1:0] SHALL exist, cleared on IDLE->WRITE and DONE->WRITE and on reset, updated to CSUM+in_data (mod 2^DATA_WIDTH) on every transfer, stable while done=1.
REQ-029: Macro MEM_FILL_CHECKSUM_EN undefined: no CSUM port and no checksum logic; all other behaviour identical.

Verification
REQ-030: Reset, start=1 one cycle, in_valid=1 constantly, in_data=addr[7:0] -> 1024 WE pulses on consecutive cycles, ADDR 0..1023, DATA=ADDR[7:0], done=1 on the cycle of the 1024th WE.
REQ-031: in_valid toggled 1,0,0,1 pattern over the full pass -> still exactly 1024 writes, ascending addresses, data matches the accepted bytes in order.
REQ-032: start pulsed again at write 500 -> ignored; pass completes with 1024 writes; then start in DONE -> done=0 next cycle, new pass restarts at ADDR=0.
REQ-033: rst_n=0 at write 300 -> all outputs 0 immediately; no WE until new start; new pass begins at ADDR=0.
REQ-034: in_valid=1 while IDLE or DONE -> in_ready=0, no WE, ADDR unchanged.
REQ-035: With MEM_FILL_CHECKSUM_EN, data=0xFF for all 1024 bytes -> CSUM=0x00 at done; data=0x01 for all bytes -> CSUM=0x00; data 0x03 at address 0, 0x00 elsewhere -> CSUM=0x03.
